// File: rtl/id_logic_decode_if.sv
// Issue-side handshake bundle for the logic decode stage: the incoming
// instruction/operand channel plus the decoded EX bundle channel.
interface id_logic_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  ex_op;
    logic [31:0] ex_src0;
    logic [31:0] ex_src1;
    logic        ex_wreg;
    logic [4:0]  ex_waddr;
    logic        illegal;

    // Producer of instructions and consumer of decoded bundles
    modport master (
        output in_valid, inst, rs_data, rt_data, out_ready,
        input  in_ready, out_valid, ex_op, ex_src0, ex_src1,
               ex_wreg, ex_waddr, illegal
    );

    // The decode stage itself
    modport slave (
        input  in_valid, inst, rs_data, rt_data, out_ready,
        output in_ready, out_valid, ex_op, ex_src0, ex_src1,
               ex_wreg, ex_waddr, illegal
    );
endinterface

// File: rtl/id_logic_decode.sv
// Decode stage for the logic execution unit. Turns AND/OR/XOR, their
// immediate forms and LUI into an op/src0/src1 bundle and holds it in a
// two-entry registered skid buffer so ID->EX can stream at full rate.
module id_logic_decode (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    id_logic_decode_if.slave bus
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] src0;
        logic [31:0] src1;
        logic        wreg;
        logic [4:0]  waddr;
        logic        illegal;
    } bundle_t;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       in_ready_q;
    bundle_t    head;
    bundle_t    skid;
    bundle_t    dec;
    bundle_t    out_bundle;
    logic       out_valid;
    logic       xfer_in;
    logic       xfer_out;
    logic       load_head_dec;
    logic       load_head_skid;
    logic       load_skid;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [15:0] imm;
    logic       supported;
    logic       use_imm;
    logic       is_lui;
    logic [3:0] concrete;
    logic [4:0] waddr;
    logic       unused_shamt;

    assign opcode       = bus.inst[31:26];
    assign funct        = bus.inst[5:0];
    assign imm          = bus.inst[15:0];
    assign unused_shamt = ^bus.inst[10:6];

    // Decode the raw instruction into the EX bundle; unsupported words become an illegal NOP
    always_comb begin
        supported = 1'b0;
        use_imm   = 1'b0;
        is_lui    = 1'b0;
        concrete  = 4'h0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h24:   begin supported = 1'b1; concrete = 4'h0; end
                    6'h25:   begin supported = 1'b1; concrete = 4'h1; end
                    6'h26:   begin supported = 1'b1; concrete = 4'h2; end
                    default: supported = 1'b0;
                endcase
            end
            6'h0C: begin supported = 1'b1; use_imm = 1'b1; concrete = 4'h0; end
            6'h0D: begin supported = 1'b1; use_imm = 1'b1; concrete = 4'h1; end
            6'h0E: begin supported = 1'b1; use_imm = 1'b1; concrete = 4'h2; end
            6'h0F: begin supported = 1'b1; use_imm = 1'b1; is_lui = 1'b1; concrete = 4'h3; end
            default: supported = 1'b0;
        endcase

        waddr = use_imm ? bus.inst[20:16] : bus.inst[15:11];

        dec = '0;
        if (supported) begin
            dec.op    = {4'h1, concrete};
            dec.src0  = is_lui ? 32'h0 : bus.rs_data;
            dec.src1  = use_imm ? {16'h0, imm} : bus.rt_data;
            dec.waddr = waddr;
            dec.wreg  = (waddr != 5'd0);
        end else begin
            dec.illegal = 1'b1;
        end
    end

    assign out_valid = (state != EMPTY);
    assign xfer_in   = bus.in_valid & in_ready_q;
    assign xfer_out  = out_valid & bus.out_ready;

    // Work out the next buffer occupancy and which payload registers load this cycle
    always_comb begin
        state_next     = state;
        load_head_dec  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (xfer_in) begin
                    state_next    = ONE;
                    load_head_dec = 1'b1;
                end
            end
            ONE: begin
                if (xfer_in && xfer_out) begin
                    load_head_dec = 1'b1;
                end else if (xfer_in) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (xfer_out) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (xfer_out) begin
                    state_next     = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next     = EMPTY;
            load_head_dec  = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Occupancy state and the registered ready, which looks one state ahead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != TWO);
        end
    end

    // Head and skid payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_dec) begin
                head <= dec;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= dec;
            end
        end
    end

    // Empty buffer presents an all-zero bundle so stale payload never leaks out
    assign out_bundle = out_valid ? head : '0;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.ex_op     = out_bundle.op;
    assign bus.ex_src0   = out_bundle.src0;
    assign bus.ex_src1   = out_bundle.src1;
    assign bus.ex_wreg   = out_bundle.wreg;
    assign bus.ex_waddr  = out_bundle.waddr;
    assign bus.illegal   = out_bundle.illegal;

endmodule

// File: tb/tb_id_logic_decode.sv
// Self-checking bench for id_logic_decode: directed decode vectors,
// backpressure / flush / mid-stream reset sequences, and a randomized
// run compared against a queue-based reference of the stage.
module tb_id_logic_decode;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    id_logic_decode_if bus ();

    id_logic_decode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] src0;
        logic [31:0] src1;
        logic        wreg;
        logic [4:0]  waddr;
        logic        illegal;
    } bundle_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_op;
        logic [31:0] exp_src0;
        logic [31:0] exp_src1;
        logic [31:0] exp_wreg;
        logic [31:0] exp_waddr;
        logic [31:0] exp_illegal;
    } vector_t;

    int testCount = 0;
    int failCount = 0;
    bundle_t modelQ[$];

    // Reference decode written from the instruction rules: pick the op index arithmetically
    function automatic bundle_t refDecode(logic [31:0] inst, logic [31:0] rs, logic [31:0] rt);
        bundle_t b;
        int opc;
        int fn;
        int sub;
        bit isImm;
        b     = '0;
        opc   = int'(inst[31:26]);
        fn    = int'(inst[5:0]);
        sub   = -1;
        isImm = 1'b0;
        if (opc == 0 && fn >= 36 && fn <= 38) begin
            sub = fn - 36;
        end else if (opc >= 12 && opc <= 15) begin
            sub   = opc - 12;
            isImm = 1'b1;
        end
        if (sub < 0) begin
            b.illegal = 1'b1;
            return b;
        end
        b.op    = 8'(16 + sub);
        b.src0  = (sub == 3) ? 32'h0 : rs;
        b.src1  = isImm ? {16'h0, inst[15:0]} : rt;
        b.waddr = isImm ? inst[20:16] : inst[15:11];
        b.wreg  = (b.waddr != 5'd0);
        return b;
    endfunction

    task automatic checkField(string name, logic [31:0] act, logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the reference buffer contents
    task automatic checkOutput(string tag);
        bundle_t expB;
        expB = (modelQ.size() > 0) ? modelQ[0] : '0;
        checkField({tag, "_in_ready"},  32'(bus.in_ready),  32'(modelQ.size() < 2));
        checkField({tag, "_out_valid"}, 32'(bus.out_valid), 32'(modelQ.size() > 0));
        checkField({tag, "_ex_op"},     32'(bus.ex_op),     32'(expB.op));
        checkField({tag, "_ex_src0"},   bus.ex_src0,        expB.src0);
        checkField({tag, "_ex_src1"},   bus.ex_src1,        expB.src1);
        checkField({tag, "_ex_wreg"},   32'(bus.ex_wreg),   32'(expB.wreg));
        checkField({tag, "_ex_waddr"},  32'(bus.ex_waddr),  32'(expB.waddr));
        checkField({tag, "_illegal"},   32'(bus.illegal),   32'(expB.illegal));
    endtask

    task automatic applyStimulus(logic valid, logic [31:0] inst, logic [31:0] rs,
                                 logic [31:0] rt, logic ordy, logic fl);
        bus.in_valid  = valid;
        bus.inst      = inst;
        bus.rs_data   = rs;
        bus.rt_data   = rt;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    // Advance the reference over one edge using the present inputs, then compare
    task automatic tick(string tag);
        bit acc;
        bit pop;
        bundle_t nb;
        acc = bus.in_valid && (modelQ.size() < 2);
        pop = (modelQ.size() > 0) && bus.out_ready;
        nb  = refDecode(bus.inst, bus.rs_data, bus.rt_data);
        if (flush) begin
            modelQ.delete();
        end else begin
            if (pop) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(nb);
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    function automatic logic [31:0] randInst();
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  rsF;
        logic [4:0]  rtF;
        logic [4:0]  rdF;
        logic [4:0]  sh;
        int sel;
        sel = int'($urandom_range(0, 7));
        rsF = 5'($urandom);
        rtF = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        rdF = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        sh  = 5'($urandom);
        fn  = 6'($urandom);
        opc = 6'($urandom);
        if (sel <= 2) begin
            opc = 6'h00;
            if ($urandom_range(0, 3) != 0) fn = 6'(6'h24 + $urandom_range(0, 2));
        end else if (sel <= 5) begin
            opc = 6'(6'h0C + $urandom_range(0, 3));
        end else if (sel == 6) begin
            opc = 6'h23;
        end
        return {opc, rsF, rtF, rdF, sh, fn};
    endfunction

    vector_t vecs[10];

    initial begin
        vecs[0] = '{32'h00851024, 32'hF0F000FF, 32'h0FF0FF00, 32'h10, 32'hF0F000FF, 32'h0FF0FF00, 1, 2, 0};
        vecs[1] = '{32'h3C03ABCD, 32'h12345678, 32'h9ABCDEF0, 32'h13, 32'h0, 32'h0000ABCD, 1, 3, 0};
        vecs[2] = '{32'h34001234, 32'hCAFEF00D, 32'h11111111, 32'h11, 32'hCAFEF00D, 32'h00001234, 0, 0, 0};
        vecs[3] = '{32'h8C000000, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h00, 32'h0, 32'h0, 0, 0, 1};
        vecs[4] = '{32'h00223825, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h11, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 7, 0};
        vecs[5] = '{32'h00640026, 32'h0000FFFF, 32'hFFFF0000, 32'h12, 32'h0000FFFF, 32'hFFFF0000, 0, 0, 0};
        vecs[6] = '{32'h3109FFFF, 32'h87654321, 32'h0, 32'h10, 32'h87654321, 32'h0000FFFF, 1, 9, 0};
        vecs[7] = '{32'h381F8001, 32'h00000001, 32'h2, 32'h12, 32'h00000001, 32'h00008001, 1, 31, 0};
        vecs[8] = '{32'h00851020, 32'h13579BDF, 32'h2468ACE0, 32'h00, 32'h0, 32'h0, 0, 0, 1};
        vecs[9] = '{32'h3C00FFFF, 32'h77777777, 32'h88888888, 32'h13, 32'h0, 32'h0000FFFF, 0, 0, 0};

        // Reset state
        rst_n = 1'b0;
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkField("rst_in_ready",  32'(bus.in_ready),  1);
        checkField("rst_out_valid", 32'(bus.out_valid), 0);
        checkField("rst_ex_op",     32'(bus.ex_op),     0);
        checkField("rst_ex_src0",   bus.ex_src0,        0);
        checkField("rst_ex_src1",   bus.ex_src1,        0);
        checkField("rst_ex_wreg",   32'(bus.ex_wreg),   0);
        checkField("rst_ex_waddr",  32'(bus.ex_waddr),  0);
        checkField("rst_illegal",   32'(bus.illegal),   0);
        rst_n = 1'b1;
        modelQ.delete();

        // Directed decode vectors, one instruction at a time
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, vecs[i].inst, vecs[i].rs, vecs[i].rt, 1, 0);
            #1;
            checkField("vec_no_comb_path", 32'(bus.out_valid), 0);
            tick("vec");
            checkField("vec_valid",   32'(bus.out_valid), 1);
            checkField("vec_op",      32'(bus.ex_op),     vecs[i].exp_op);
            checkField("vec_src0",    bus.ex_src0,        vecs[i].exp_src0);
            checkField("vec_src1",    bus.ex_src1,        vecs[i].exp_src1);
            checkField("vec_wreg",    32'(bus.ex_wreg),   vecs[i].exp_wreg);
            checkField("vec_waddr",   32'(bus.ex_waddr),  vecs[i].exp_waddr);
            checkField("vec_illegal", 32'(bus.illegal),   vecs[i].exp_illegal);
            applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);
            tick("vec_drain");
        end

        // Backpressure: four ORIs against a stalled consumer, then release
        begin
            int sent = 0;
            int got = 0;
            int gaps = 0;
            bit release_ = 1'b0;
            for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
                bit accept;
                if (sent >= 2 && !release_) begin
                    checkField("bp_in_ready_full", 32'(bus.in_ready), 0);
                    checkField("bp_head_held", bus.ex_src1, 32'h100);
                    release_ = 1'b1;
                end
                if (release_) begin
                    if (bus.out_valid) begin
                        checkField("bp_order", bus.ex_src1, 32'(32'h100 + got));
                        got++;
                    end else begin
                        gaps++;
                    end
                end
                if (sent < 4) begin
                    applyStimulus(1, {6'h0D, 5'd1, 5'(sent + 1), 16'(16'h100 + sent)},
                                  32'h0F0F0000, 32'h0, release_, 0);
                end else begin
                    applyStimulus(0, 32'h0, 32'h0, 32'h0, release_, 0);
                end
                accept = bus.in_valid && bus.in_ready;
                tick("bp");
                if (accept) sent++;
            end
            checkField("bp_delivered", 32'(got), 4);
            checkField("bp_gaps", 32'(gaps), 0);
            applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);
            tick("bp_drain");
        end

        // Flush while holding two entries with an input offered at the same time
        applyStimulus(1, 32'h38010055, 32'h0, 32'h0, 0, 0);
        tick("fl_fill");
        applyStimulus(1, 32'h38020066, 32'h0, 32'h0, 0, 0);
        tick("fl_fill");
        checkField("fl_full", 32'(bus.in_ready), 0);
        applyStimulus(1, 32'h38030077, 32'h0, 32'h0, 0, 1);
        tick("fl_flush");
        checkField("fl_out_valid", 32'(bus.out_valid), 0);
        checkField("fl_in_ready",  32'(bus.in_ready),  1);
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick("fl_after");
            checkField("fl_no_ghost", 32'(bus.out_valid), 0);
        end

        // Flush with one entry and an acceptable input: the input is dropped too
        applyStimulus(1, 32'h34040011, 32'h1, 32'h0, 0, 0);
        tick("fl1_fill");
        applyStimulus(1, 32'h34050022, 32'h1, 32'h0, 1, 1);
        tick("fl1_flush");
        checkField("fl1_out_valid", 32'(bus.out_valid), 0);
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 1, 0);
        tick("fl1_after");

        // Asynchronous reset in the middle of a stream
        applyStimulus(1, 32'h3406AAAA, 32'h0, 32'h0, 0, 0);
        tick("mr_fill");
        tick("mr_fill");
        #2;
        rst_n = 1'b0;
        #1;
        modelQ.delete();
        checkField("mr_out_valid", 32'(bus.out_valid), 0);
        checkField("mr_in_ready",  32'(bus.in_ready),  1);
        checkField("mr_ex_src1",   bus.ex_src1,        0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 32'h3007BBBB, 32'h5, 32'h0, 1, 0);
        tick("mr_first");
        checkField("mr_first_accept", 32'(bus.out_valid), 1);
        checkField("mr_first_src1",   bus.ex_src1,        32'h0000BBBB);

        // Randomized stream against the reference buffer
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), randInst(), $urandom, $urandom,
                          ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
